// File: rtl/ads1675_pkg.sv
// Shared ADS1675 constants, FSM encodings and the DW->SW signed saturation helper.
package ads1675_pkg;
    localparam int ADS_DW       = 32;
    localparam int ADS_SW       = 24;
    localparam int ADS_FRAME_2M = 48;
    localparam logic DRDY_ACTIVE = 1'b0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Clamp to the SW-bit signed range when the dropped upper bits differ from the sign.
    function automatic logic [ADS_SW-1:0] ads_sat(input logic [ADS_DW-1:0] din);
        logic [ADS_DW-ADS_SW:0] hi;
        hi = din[ADS_DW-1:ADS_SW-1];
        if ((&hi) || (~|hi))
            ads_sat = din[ADS_SW-1:0];
        else if (din[ADS_DW-1])
            ads_sat = {1'b1, {(ADS_SW-1){1'b0}}};
        else
            ads_sat = {1'b0, {(ADS_SW-1){1'b1}}};
    endfunction
endpackage

// File: rtl/ads1675_sat.sv
// Combinational signed saturation from DW to SW bits, shared with the capture-side checker.
module ads1675_sat #(
    parameter int DW = 32,
    parameter int SW = 24
) (
    input  logic [DW-1:0] din,
    output logic [SW-1:0] dout
);
    logic [DW-SW:0] hi;

    assign hi = din[DW-1:SW-1];

    always_comb begin
        if ((&hi) || (~|hi))
            dout = din[SW-1:0];
        else if (din[DW-1])
            dout = {1'b1, {(SW-1){1'b0}}};
        else
            dout = {1'b0, {(SW-1){1'b1}}};
    end
endmodule

// File: rtl/ads1675_frame_tx.sv
// ADS1675 transmit emulator: AXIS samples serialised as DRDY/DOUT frames, one per FRAME sclk cycles.
// Define ADS1675_TX_RAMP_EN to add the ramp_en input and the internal ramp test-pattern source.
//
// state | meaning
// IDLE  | start low: counter parked at 0, drdy_n high, dout low
// RUN   | frames back to back; cnt is the bit position inside the current frame
module ads1675_frame_tx
    import ads1675_pkg::*;
#(
    parameter int DW    = ADS_DW,
    parameter int SW    = ADS_SW,
    parameter int FRAME = ADS_FRAME_2M
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          start,
    input  logic          cs_n,
`ifdef ADS1675_TX_RAMP_EN
    input  logic          ramp_en,
`endif
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tlast,
    output logic          drdy_n,
    output logic          dout,
    output logic          underflow,
    output logic [15:0]   underflow_cnt
);
    localparam int CW = $clog2(FRAME);

    if (FRAME < SW + 1) begin : g_frame_chk
        $error("ads1675_frame_tx: FRAME must be at least SW+1");
    end
    if (SW > DW) begin : g_width_chk
        $error("ads1675_frame_tx: SW must not exceed DW");
    end

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] hold_q;
    logic          hold_vld;
    logic [SW-1:0] last_q;
    logic [SW-1:0] shreg;
    logic [SW-1:0] sat_val;
    logic [SW-1:0] frame_val;
    logic          frame_start;
    logic          accept;
    logic          ramp_on;
    logic          unused_tlast;

    assign unused_tlast = s_axis_tlast;

`ifdef ADS1675_TX_RAMP_EN
    logic [SW-1:0] ramp_q;

    assign ramp_on = ramp_en;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst)
            ramp_q <= '0;
        else if (frame_start && ramp_en)
            ramp_q <= ramp_q + 1'b1;
    end
`else
    assign ramp_on = 1'b0;
`endif

    ads1675_sat #(.DW(DW), .SW(SW)) u_sat (
        .din  (s_axis_tdata),
        .dout (sat_val)
    );

    // Ready is forced low while rst is asserted, not just after the first clock.
    assign s_axis_tready = ~hold_vld & ~rst & ~ramp_on;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign frame_start   = (state == ST_RUN) && start && (cnt == '0);

    always_comb begin
        frame_val = hold_vld ? hold_q : last_q;
`ifdef ADS1675_TX_RAMP_EN
        if (ramp_en)
            frame_val = ramp_q;
`endif
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (frame_start && !ramp_on)
                hold_vld <= 1'b0;
            if (accept) begin
                hold_q   <= sat_val;
                hold_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            drdy_n        <= ~DRDY_ACTIVE;
            dout          <= 1'b0;
            shreg         <= '0;
            last_q        <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            underflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt    <= '0;
                    drdy_n <= ~DRDY_ACTIVE;
                    dout   <= 1'b0;
                    if (start)
                        state <= ST_RUN;
                end
                default: begin
                    if (!start) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        drdy_n <= ~DRDY_ACTIVE;
                        dout   <= 1'b0;
                    end else if (cnt == '0) begin
                        cnt    <= 1'b1;
                        drdy_n <= DRDY_ACTIVE;
                        dout   <= frame_val[SW-1] & ~cs_n;
                        shreg  <= {frame_val[SW-2:0], 1'b0};
                        last_q <= frame_val;
                        if (!hold_vld && !ramp_on) begin
                            underflow <= 1'b1;
                            if (underflow_cnt != 16'hFFFF)
                                underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end else begin
                        // Zeros shift in behind the sample, so bits SW..FRAME-1 go out as 0.
                        cnt    <= (cnt == CW'(FRAME - 1)) ? '0 : cnt + 1'b1;
                        drdy_n <= ~DRDY_ACTIVE;
                        dout   <= shreg[SW-1] & ~cs_n;
                        shreg  <= {shreg[SW-2:0], 1'b0};
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ads1675_frame_tx.sv
// Randomized scoreboard bench for ads1675_frame_tx: a loopback frame monitor checks every frame.
`timescale 1ns/1ps
module tb_ads1675_frame_tx;
    localparam int DW    = 32;
    localparam int SW    = 24;
    localparam int FRAME = 48;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cs_n = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          drdy_n;
    logic          dout;
    logic          underflow;
    logic [15:0]   underflow_cnt;
`ifdef ADS1675_TX_RAMP_EN
    logic          ramp_en = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [SW-1:0] val;
        longint        cyc;
    } beat_t;

    beat_t         exp_q[$];
    longint        cyc = 0;
    logic          cs_edge = 1'b0;
    logic [SW-1:0] last_model = '0;
    logic [SW-1:0] ramp_model = '0;
    int            exp_uf = 0;

    ads1675_frame_tx dut (
        .sclk          (sclk),
        .rst           (rst),
        .start         (start),
        .cs_n          (cs_n),
`ifdef ADS1675_TX_RAMP_EN
        .ramp_en       (ramp_en),
`endif
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .drdy_n        (drdy_n),
        .dout          (dout),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 sclk = ~sclk;

    // Edge counter and the cs_n value the DUT saw at each rising edge.
    always @(posedge sclk) begin
        cyc     <= cyc + 1;
        cs_edge <= cs_n;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [SW-1:0] sat_model(input logic [DW-1:0] d);
        longint v, hi_lim, lo_lim;
        logic [63:0] r;
        v      = longint'($signed(d));
        hi_lim = (longint'(1) <<< (SW - 1)) - 1;
        lo_lim = -(hi_lim + 1);
        if (v > hi_lim)
            v = hi_lim;
        else if (v < lo_lim)
            v = lo_lim;
        r = 64'(v);
        return r[SW-1:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        int w;
        w = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = 1'b1;
        while (!s_axis_tready && w < 4 * FRAME) begin
            @(negedge sclk);
            w++;
        end
        check("send_accept", s_axis_tready, 1);
        if (!s_axis_tready) begin
            s_axis_tvalid = 1'b0;
            return;
        end
        exp_q.push_back('{sat_model(d), cyc + 1});
        @(negedge sclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("tready_low_when_full", s_axis_tready, 0);
    endtask

    task automatic wait_frame();
        int w;
        w = 0;
        do begin
            @(negedge sclk);
            w++;
        end while (drdy_n !== 1'b0 && w < 3 * FRAME);
        check("frame_seen", drdy_n, 0);
    endtask

    // Loopback capture: each DRDY strobe opens a frame that is compared against the scoreboard.
    initial begin : monitor
        logic [SW-1:0] exp_v, got, exp_w;
        logic          from_q, aborted, tail_bad, drdy_bad, ramp_now, prev_ok;
        longint        e, prev_e;
        prev_ok = 1'b0;
        prev_e  = 0;
        forever begin
            @(negedge sclk);
            if (!start)
                prev_ok = 1'b0;
            if (!rst && drdy_n === 1'b0) begin
                e        = cyc;
                ramp_now = 1'b0;
`ifdef ADS1675_TX_RAMP_EN
                ramp_now = ramp_en;
`endif
                if (ramp_now) begin
                    exp_v      = ramp_model;
                    ramp_model = ramp_model + 1'b1;
                    from_q     = 1'b1;
                end else if (exp_q.size() > 0 && exp_q[0].cyc < e) begin
                    exp_v  = exp_q.pop_front().val;
                    from_q = 1'b1;
                end else begin
                    exp_v  = last_model;
                    from_q = 1'b0;
                    exp_uf++;
                end
                last_model = exp_v;
                check("underflow_pulse", underflow, from_q ? 0 : 1);
                got      = '0;
                exp_w    = '0;
                aborted  = 1'b0;
                tail_bad = 1'b0;
                drdy_bad = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0)
                        @(negedge sclk);
                    if (!start) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k > 0 && drdy_n !== 1'b1)
                        drdy_bad = 1'b1;
                    if (k < SW) begin
                        got[SW-1-k]   = dout;
                        exp_w[SW-1-k] = exp_v[SW-1-k] & ~cs_edge;
                    end else if (dout !== 1'b0) begin
                        tail_bad = 1'b1;
                    end
                end
                if (!aborted) begin
                    check("frame_data", got, exp_w);
                    check("frame_tail_zero", tail_bad, 0);
                    check("drdy_single_cycle", drdy_bad, 0);
                    if (prev_ok)
                        check("frame_period", e - prev_e, FRAME);
                end
                prev_e  = e;
                prev_ok = !aborted;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic flag;
        repeat (5) @(negedge sclk);
        check("rst_drdy_n", drdy_n, 1);
        check("rst_dout", dout, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_underflow", underflow, 0);
        check("rst_underflow_cnt", underflow_cnt, 0);
        rst = 1'b0;
        @(negedge sclk);
        check("tready_after_rst", s_axis_tready, 1);
        check("ucnt_after_rst", underflow_cnt, 0);

        // Single sample, then start: first frame carries it.
        send(32'h0012_3456);
        start = 1'b1;
        wait_frame();

        // Saturation corners.
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        send(32'hFFFF_FFFF);
        wait_frame();
        wait_frame();

        // One sample then starvation for two frames.
        wait_frame();
        send(32'h0000_0ABC);
        wait_frame();
        wait_frame();
        wait_frame();
        @(negedge sclk);
        check("ucnt_after_starve", underflow_cnt, exp_uf);

        // Burst of three beats under back-pressure.
        wait_frame();
        send(32'h0011_1111);
        send(32'hFFEE_EEEE);
        send(32'h0033_3333);
        wait_frame();
        wait_frame();

        // Randomized beats, gaps and chip-select.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge sclk);
            cs_n = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1)
                send($urandom);
            else
                send(32'($signed(24'($urandom_range(0, 32'h00FF_FFFF)))));
        end
        cs_n = 1'b0;

        // Abort at bit 10 with a sample waiting in the buffer.
        wait_frame();
        check("tready_at_frame_start", s_axis_tready, 1);
        send(32'h0055_AA33);
        repeat (9) @(negedge sclk);
        start = 1'b0;
        @(negedge sclk);
        check("abort_drdy_n", drdy_n, 1);
        check("abort_dout", dout, 0);
        flag = 1'b0;
        repeat (6) begin
            @(negedge sclk);
            if (drdy_n !== 1'b1 || dout !== 1'b0)
                flag = 1'b1;
        end
        check("idle_quiet", flag, 0);
        start = 1'b1;
        @(negedge sclk);
        check("restart_wait_drdy", drdy_n, 1);
        @(negedge sclk);
        check("restart_frame_drdy", drdy_n, 0);

        // Chip-select high: DRDY keeps running, DOUT stays low.
        repeat (2) @(negedge sclk);
        cs_n = 1'b1;
        wait_frame();
        flag = 1'b0;
        repeat (FRAME) begin
            @(negedge sclk);
            if (dout !== 1'b0)
                flag = 1'b1;
        end
        check("cs_high_dout_low", flag, 0);
        check("cs_high_drdy_runs", drdy_n, 0);
        cs_n = 1'b0;
        wait_frame();

`ifdef ADS1675_TX_RAMP_EN
        start = 1'b0;
        repeat (4) @(negedge sclk);
        ramp_en = 1'b1;
        @(negedge sclk);
        check("ramp_tready", s_axis_tready, 0);
        start = 1'b1;
        repeat (4) wait_frame();
        start = 1'b0;
        repeat (4) @(negedge sclk);
        ramp_en = 1'b0;
`endif

        start = 1'b0;
        repeat (FRAME + 5) @(negedge sclk);
        check("final_underflow_cnt", underflow_cnt, exp_uf);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
